// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command sequencer for the 8-bit ALU: parses command/operand bytes,
// pulses the ALU enable, captures the 16-bit result and streams it out LO then HI.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [3:0] FUN_ILLEGAL = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_ISSUE,
    S_WAIT_RES,
    S_SEND_LO,
    S_SEND_HI
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [3:0]            r_fun;
  logic [RES_WIDTH-1:0]  r_res;
  logic [CW-1:0]         r_cnt;
  logic                  r_err;

  logic w_rx_acc;
  logic w_tx_acc;
  logic w_cmd_illegal;
  logic w_fun_illegal;
  logic w_timeout;
  logic w_err_set;
  logic w_unused;

  // Command bits [6:4] carry no meaning in this revision.
  assign w_unused = ^RX_DATA[6:4];

  assign w_rx_acc      = RX_VALID && RX_READY;
  assign w_tx_acc      = TX_VALID && TX_READY;
  assign w_cmd_illegal = (RX_DATA[3:0] == FUN_ILLEGAL);
  assign w_fun_illegal = (r_fun == FUN_ILLEGAL);
  assign w_timeout     = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_acc) begin
          if (RX_DATA[7]) begin
            w_next = S_GET_A;
          end else if (w_cmd_illegal) begin
            w_next    = S_IDLE;
            w_err_set = 1'b1;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_GET_A: begin
        if (w_rx_acc) w_next = S_GET_B;
      end
      S_GET_B: begin
        if (w_rx_acc) begin
          if (w_fun_illegal) begin
            w_next    = S_IDLE;
            w_err_set = 1'b1;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (ALU_OUT_VALID) begin
          w_next = S_SEND_LO;
        end else if (w_timeout) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_SEND_LO: begin
        if (w_tx_acc) w_next = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (w_tx_acc) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operands and function persist across frames; only reset clears them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_fun <= '0;
    end else begin
      if (r_state == S_IDLE && w_rx_acc) r_fun <= RX_DATA[3:0];
      if (r_state == S_GET_A && w_rx_acc) r_a <= RX_DATA;
      if (r_state == S_GET_B && w_rx_acc) r_b <= RX_DATA;
    end
  end

  // Wait counter runs from 0 on WAIT_RES entry; result captured on first valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_res <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_set;
      if (r_state == S_WAIT_RES) begin
        r_cnt <= r_cnt + CW'(1);
        if (ALU_OUT_VALID) r_res <= ALU_OUT;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    RX_READY = 1'b0;
    ALU_EN   = 1'b0;
    TX_VALID = 1'b0;
    TX_DATA  = '0;
    case (r_state)
      S_IDLE, S_GET_A, S_GET_B: RX_READY = 1'b1;
      S_ISSUE:                  ALU_EN   = 1'b1;
      S_SEND_LO: begin
        TX_VALID = 1'b1;
        TX_DATA  = r_res[DATA_WIDTH-1:0];
      end
      S_SEND_HI: begin
        TX_VALID = 1'b1;
        TX_DATA  = r_res[RES_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  assign BUSY    = (r_state != S_IDLE);
  assign ERR     = r_err;
  assign ALU_A   = r_a;
  assign ALU_B   = r_b;
  assign ALU_FUN = r_fun;

endmodule
